ship_plotter: RTL and testbench

- Consumes the ship position and plot strobe produced by the spaceship block.
- Turns each plot request into a pixel-write stream for the 160x120 VGA adapter.
- Each request erases the sprite box at the previously drawn position, then draws the sprite box at the new position.
- Sits between the ship logic and the VGA adapter's x/y/colour/writeEn inputs.

---
 rtl/ship_plotter_if.sv | 23 ++
 rtl/ship_plotter.sv | 188 ++++++++++++++++++
 tb/tb_ship_plotter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ship_plotter_if.sv
// Request/VGA-write bundle between the ship logic, the plotter and the 160x120 VGA adapter.
interface ship_plotter_if;
  logic       plot_req;
  logic [7:0] ship_x;
  logic [6:0] ship_y;
  logic       visible;
  logic       busy;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_write;

  modport master (
    output plot_req, ship_x, ship_y, visible,
    input  busy, done, vga_x, vga_y, vga_colour, vga_write
  );

  modport slave (
    input  plot_req, ship_x, ship_y, visible,
    output busy, done, vga_x, vga_y, vga_colour, vga_write
  );
endinterface

// File: rtl/ship_plotter.sv
// Erases the sprite box at the last drawn position, then draws it at the new one, one pixel/cycle.
// Optional SHIP_PLOTTER_SHAPE_EN swaps the solid draw box for a fixed 4x4 ship mask.
module ship_plotter #(
  parameter int         SPRITE_W    = 4,
  parameter int         SPRITE_H    = 4,
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter logic [2:0] SHIP_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input logic           clk,
  input logic           reset,
  ship_plotter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FIN} state_t;

  localparam logic [2:0] LAST_COL = 3'(SPRITE_W - 1);
  localparam logic [2:0] LAST_ROW = 3'(SPRITE_H - 1);

  state_t     state, state_nxt;
  logic [2:0] col, col_nxt;
  logic [2:0] row, row_nxt;
  logic [7:0] new_x, new_x_nxt, old_x, old_x_nxt;
  logic [6:0] new_y, new_y_nxt, old_y, old_y_nxt;
  logic       new_vis, new_vis_nxt;
  logic       old_valid, old_valid_nxt;
  logic       busy_r, busy_nxt;
  logic       done_r, done_nxt;
  logic       write_r, write_nxt;
  logic [7:0] x_r, x_nxt;
  logic [6:0] y_r, y_nxt;
  logic [2:0] colour_r, colour_nxt;
  logic       last_col, last_pix;

  // Single conditional subtraction; the 9-bit sum is compared before any truncation.
  function automatic logic [7:0] wrap_x(input logic [7:0] base, input logic [2:0] off);
    logic [8:0] s;
    s = {1'b0, base} + {6'b0, off};
    if (s >= 9'(SCREEN_W)) s = s - 9'(SCREEN_W);
    return s[7:0];
  endfunction

  function automatic logic [6:0] wrap_y(input logic [6:0] base, input logic [2:0] off);
    logic [7:0] s;
    s = {1'b0, base} + {5'b0, off};
    if (s >= 8'(SCREEN_H)) s = s - 8'(SCREEN_H);
    return s[6:0];
  endfunction

`ifdef SHIP_PLOTTER_SHAPE_EN
  generate
    if (SPRITE_W != 4 || SPRITE_H != 4) begin : g_shape_size_check
      $error("ship_plotter: shape mask needs a 4x4 sprite");
    end
  endgenerate

  // Row-major mask, MSB of each row is column 0.
  localparam logic [3:0] SHAPE_ROWS [4] = '{4'b0110, 4'b1111, 4'b1111, 4'b1001};

  function automatic logic [2:0] draw_colour(input logic [2:0] r, input logic [2:0] c);
    logic [1:0] bit_sel;
    bit_sel = 2'd3 - c[1:0];
    return SHAPE_ROWS[r[1:0]][bit_sel] ? SHIP_COLOUR : BG_COLOUR;
  endfunction
`else
  function automatic logic [2:0] draw_colour(input logic [2:0] r, input logic [2:0] c);
    return (r <= LAST_ROW && c <= LAST_COL) ? SHIP_COLOUR : BG_COLOUR;
  endfunction
`endif

  assign last_col = (col == LAST_COL);
  assign last_pix = last_col && (row == LAST_ROW);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      new_x     <= '0;
      new_y     <= '0;
      new_vis   <= 1'b0;
      old_x     <= '0;
      old_y     <= '0;
      old_valid <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      write_r   <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      colour_r  <= BG_COLOUR;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      new_x     <= new_x_nxt;
      new_y     <= new_y_nxt;
      new_vis   <= new_vis_nxt;
      old_x     <= old_x_nxt;
      old_y     <= old_y_nxt;
      old_valid <= old_valid_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
      write_r   <= write_nxt;
      x_r       <= x_nxt;
      y_r       <= y_nxt;
      colour_r  <= colour_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    col_nxt       = col;
    row_nxt       = row;
    new_x_nxt     = new_x;
    new_y_nxt     = new_y;
    new_vis_nxt   = new_vis;
    old_x_nxt     = old_x;
    old_y_nxt     = old_y;
    old_valid_nxt = old_valid;
    busy_nxt      = busy_r;
    done_nxt      = 1'b0;
    write_nxt     = 1'b0;
    x_nxt         = x_r;
    y_nxt         = y_r;
    colour_nxt    = colour_r;

    unique case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (bus.plot_req) begin
          new_x_nxt   = wrap_x(bus.ship_x, 3'd0);
          new_y_nxt   = wrap_y(bus.ship_y, 3'd0);
          new_vis_nxt = bus.visible;
          busy_nxt    = 1'b1;
          col_nxt     = '0;
          row_nxt     = '0;
          if (old_valid)        state_nxt = ERASE;
          else if (bus.visible) state_nxt = DRAW;
          else                  state_nxt = FIN;
        end
      end
      ERASE: begin
        busy_nxt   = 1'b1;
        write_nxt  = 1'b1;
        x_nxt      = wrap_x(old_x, col);
        y_nxt      = wrap_y(old_y, row);
        colour_nxt = BG_COLOUR;
        if (last_pix) state_nxt = new_vis ? DRAW : FIN;
      end
      DRAW: begin
        busy_nxt   = 1'b1;
        write_nxt  = 1'b1;
        x_nxt      = wrap_x(new_x, col);
        y_nxt      = wrap_y(new_y, row);
        colour_nxt = draw_colour(row, col);
        if (last_pix) state_nxt = FIN;
      end
      FIN: begin
        busy_nxt      = 1'b0;
        done_nxt      = 1'b1;
        old_x_nxt     = new_x;
        old_y_nxt     = new_y;
        old_valid_nxt = new_vis;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Row-major walk; wraps to 0,0 so the next box starts clean.
    if (state == ERASE || state == DRAW) begin
      if (last_col) begin
        col_nxt = '0;
        row_nxt = last_pix ? 3'd0 : row + 3'd1;
      end else begin
        col_nxt = col + 3'd1;
      end
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.vga_write  = write_r;
  assign bus.vga_x      = x_r;
  assign bus.vga_y      = y_r;
  assign bus.vga_colour = colour_r;

endmodule

// File: tb/tb_ship_plotter.sv
// Directed bench for ship_plotter: pixel streams, done latency, wrap, held request, mid-op reset.
module tb_ship_plotter;
  logic clk = 1'b0;
  logic reset;

  ship_plotter_if bus();

  ship_plotter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  pix_t got_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_at;
  int   nwr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] ship_col(input int r, input int c);
`ifdef SHIP_PLOTTER_SHAPE_EN
    logic [15:0] mask;
    mask = 16'b0110_1111_1111_1001;
    return mask[15 - (r * 4 + c)] ? 3'b111 : 3'b000;
`else
    return (r >= 0 && c >= 0) ? 3'b111 : 3'b000;
`endif
  endfunction

  task automatic push_box(input int bx, input int by, input bit draw);
    pix_t p;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        p.x = 8'((bx + c) % 160);
        p.y = 7'((by + r) % 120);
        p.c = draw ? ship_col(r, c) : 3'b000;
        exp_q.push_back(p);
      end
    end
  endtask

  // Called at the negedge right after acceptance; walks to the done pulse.
  task automatic collect(input string tag, input int exp_lat);
    got_q.delete();
    done_at = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (bus.vga_write) got_q.push_back({bus.vga_x, bus.vga_y, bus.vga_colour});
      if (bus.done) begin
        done_at = n;
        break;
      end
    end
    check({tag, "_done_latency"}, done_at, exp_lat);
    check({tag, "_busy_at_done"}, bus.busy, 1'b0);
    check({tag, "_write_at_done"}, bus.vga_write, 1'b0);
    check({tag, "_write_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_pix%0d", tag, i), got_q[i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic issue(input logic [7:0] x, input logic [6:0] y, input logic vis, input string tag);
    bus.plot_req = 1'b1;
    bus.ship_x   = x;
    bus.ship_y   = y;
    bus.visible  = vis;
    @(negedge clk);
    check({tag, "_busy_rise"}, bus.busy, 1'b1);
    check({tag, "_no_write_yet"}, bus.vga_write, 1'b0);
    bus.plot_req = 1'b0;
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, bus.done, 1'b0);
    check({tag, "_idle_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.plot_req = 1'b0;
    bus.ship_x   = '0;
    bus.ship_y   = '0;
    bus.visible  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_write", bus.vga_write, 1'b0);
    check("rst_x", bus.vga_x, 8'd0);
    check("rst_y", bus.vga_y, 7'd0);
    check("rst_colour", bus.vga_colour, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    // First plot: draw only.
    push_box(10, 20, 1'b1);
    issue(8'd10, 7'd20, 1'b1, "first");
    collect("first", 17);
    after_done("first");

    // Move right by one: erase then draw.
    push_box(10, 20, 1'b0);
    push_box(11, 20, 1'b1);
    issue(8'd11, 7'd20, 1'b1, "move");
    collect("move", 33);
    after_done("move");

    // Corner wrap on both axes.
    push_box(11, 20, 1'b0);
    push_box(158, 118, 1'b1);
    issue(8'd158, 7'd118, 1'b1, "wrap");
    collect("wrap", 33);
    after_done("wrap");

    push_box(158, 118, 1'b0);
    push_box(50, 60, 1'b1);
    issue(8'd50, 7'd60, 1'b1, "to50");
    collect("to50", 33);
    after_done("to50");

    // Ship destroyed: erase only.
    push_box(50, 60, 1'b0);
    issue(8'd50, 7'd60, 1'b0, "hide");
    collect("hide", 17);
    after_done("hide");

    // Nothing on screen any more, so no erase.
    push_box(70, 30, 1'b1);
    issue(8'd70, 7'd30, 1'b1, "reappear");
    collect("reappear", 17);
    after_done("reappear");

    // Request held through the operation; changed coords must not re-latch.
    bus.plot_req = 1'b1;
    bus.ship_x   = 8'd20;
    bus.ship_y   = 7'd40;
    bus.visible  = 1'b1;
    @(negedge clk);
    check("held_busy_rise", bus.busy, 1'b1);
    bus.ship_x = 8'd99;
    push_box(70, 30, 1'b0);
    push_box(20, 40, 1'b1);
    collect("held", 33);
    @(negedge clk);
    check("held_reaccept_busy", bus.busy, 1'b1);
    check("held_reaccept_done", bus.done, 1'b0);
    bus.plot_req = 1'b0;
    push_box(20, 40, 1'b0);
    push_box(99, 40, 1'b1);
    collect("held2", 33);
    after_done("held2");

    // Out-of-range coords reduced once: 200->40, 125->5.
    push_box(99, 40, 1'b0);
    push_box(40, 5, 1'b1);
    issue(8'd200, 7'd125, 1'b1, "oor");
    collect("oor", 33);
    after_done("oor");

    // Reset on the 5th erase pixel.
    issue(8'd0, 7'd0, 1'b1, "rstmid");
    nwr = 0;
    for (int n = 0; n < 20 && nwr < 5; n++) begin
      @(negedge clk);
      if (bus.vga_write) nwr++;
    end
    check("rstmid_reached5", nwr, 5);
    check("rstmid_pix5", {bus.vga_x, bus.vga_y, bus.vga_colour}, {8'd40, 7'd6, 3'b000});
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_write", bus.vga_write, 1'b0);
    check("rstmid_busy", bus.busy, 1'b0);
    check("rstmid_done", bus.done, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    push_box(30, 30, 1'b1);
    issue(8'd30, 7'd30, 1'b1, "postrst");
    collect("postrst", 17);
    after_done("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
